// File: rtl/chain_counter_pkg.sv
// Shared constants for the cascaded digit counter.
package chain_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MAX_DIGITS  = 8;
    localparam int unsigned MAX_DIGIT_W = 8;

endpackage

// File: rtl/chain_counter_digit.sv
// One modulo-MOD digit stage: clear > load > step, with wrap inside the digit.
module chain_counter_digit
    import chain_counter_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MOD     = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               step,
    input  logic               up,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

    logic [DIGIT_W-1:0] value_nxt;

    assign at_max  = (value == MAX_V);
    assign at_zero = (value == '0);

    // Load clamps out-of-range digits so value never leaves 0..MOD-1.
    always_comb begin
        value_nxt = value;
        if (clr) begin
            value_nxt = '0;
        end else if (load) begin
            value_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                value_nxt = at_max ? '0 : value + DIGIT_W'(1);
            end else begin
                value_nxt = at_zero ? MAX_V : value - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            value <= '0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/chain_counter.sv
// Multi-digit up/down counter: DIGITS cascaded modulo-MOD stages with
// clear/load, and wrap-or-saturate behaviour at the chain boundary.
module chain_counter
    import chain_counter_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MOD     = 10,
    parameter int unsigned WRAP    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_up,
    input  logic                      i_clr,
    input  logic                      i_load,
    input  logic [DIGITS*DIGIT_W-1:0] i_load_val,
    output logic [DIGITS*DIGIT_W-1:0] o_count,
    output logic                      o_tc,
    output logic                      o_wrap,
    output logic                      o_sat
);

    localparam bit SAT_MODE = (WRAP == 0);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] step;
    logic [DIGITS:0]   carry;
    logic              tc_c;
    logic              sat_c;
    logic              wrap_nxt;

    // carry[k]: every digit below k sits at its rollover value for this direction.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            carry[k+1] = carry[k] & ((i_up == DIR_DOWN) ? at_zero[k] : at_max[k]);
        end
    end

    assign tc_c  = carry[DIGITS];
    assign sat_c = SAT_MODE & tc_c & i_en;
    assign o_tc  = tc_c;
    assign o_sat = sat_c;

    // Saturation freezes every stage; clear/load still win inside each digit.
    assign step = {DIGITS{i_en & ~sat_c}} & carry[DIGITS-1:0];

    assign wrap_nxt = !SAT_MODE && i_en && tc_c && !i_clr && !i_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wrap <= 1'b0;
        end else begin
            o_wrap <= wrap_nxt;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        chain_counter_digit #(
            .DIGIT_W (DIGIT_W),
            .MOD     (MOD)
        ) u_digit (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .step     (step[k]),
            .up       (i_up),
            .clr      (i_clr),
            .load     (i_load),
            .load_val (i_load_val[k*DIGIT_W +: DIGIT_W]),
            .value    (o_count[k*DIGIT_W +: DIGIT_W]),
            .at_max   (at_max[k]),
            .at_zero  (at_zero[k])
        );
    end

endmodule
